// File: rtl/vproc_pkg.sv
// Shared types for the vector processor configuration path: SEW/LMUL encodings,
// the vset* request descriptor and the configuration unit FSM states.
package vproc_pkg;

  typedef enum logic [1:0] {
    VSEW_8       = 2'd0,
    VSEW_16      = 2'd1,
    VSEW_32      = 2'd2,
    VSEW_INVALID = 2'd3
  } cfg_vsew;

  // Integer LMUL values occupy codes 0..3 so the code doubles as the shift amount
  typedef enum logic [2:0] {
    LMUL_1       = 3'd0,
    LMUL_2       = 3'd1,
    LMUL_4       = 3'd2,
    LMUL_8       = 3'd3,
    LMUL_INVALID = 3'd4,
    LMUL_F8      = 3'd5,
    LMUL_F4      = 3'd6,
    LMUL_F2      = 3'd7
  } cfg_lmul;

  typedef struct packed {
    cfg_vsew    vsew;
    cfg_lmul    lmul;
    logic [1:0] agnostic;
    logic       vlmax;
    logic       keep_vl;
  } op_mode_cfg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    RESP  = 2'd2
  } cfg_state_e;

  // Element width in bits for a SEW encoding
  function automatic logic [8:0] sew_bits(input cfg_vsew vsew);
    return 9'd8 << vsew;
  endfunction

endpackage

// File: rtl/vproc_vlmax_calc.sv
// Combinational VLMAX and legality evaluation for a (vsew, lmul) pair.
module vproc_vlmax_calc
  import vproc_pkg::*;
#(
  parameter int unsigned VREG_W = 128,
  parameter int unsigned CFG_W  = $clog2(8*VREG_W/8+1)
) (
  input  cfg_vsew          vsew,
  input  cfg_lmul          lmul,
  output logic [CFG_W-1:0] vlmax,
  output logic             illegal
);

  logic [CFG_W-1:0] base_s;
  logic [8:0]       lmul32_s;

  // VLMAX scaling and SEW <= LMUL*32 check
  always_comb begin
    base_s   = CFG_W'(VREG_W/8) >> vsew;
    vlmax    = '0;
    lmul32_s = 9'd0;
    case (lmul)
      LMUL_1, LMUL_2, LMUL_4, LMUL_8: begin
        vlmax    = base_s << lmul[1:0];
        lmul32_s = 9'd32 << lmul[1:0];
      end
      LMUL_F2: begin
        vlmax    = base_s >> 2'd1;
        lmul32_s = 9'd16;
      end
      LMUL_F4: begin
        vlmax    = base_s >> 2'd2;
        lmul32_s = 9'd8;
      end
      LMUL_F8: begin
        vlmax    = base_s >> 2'd3;
        lmul32_s = 9'd4;
      end
      default: begin
        vlmax    = '0;
        lmul32_s = 9'd0;
      end
    endcase
    illegal = (vsew == VSEW_INVALID) || (lmul == LMUL_INVALID) ||
              (sew_bits(vsew) > lmul32_s) || (vlmax == '0);
  end

endmodule

// File: rtl/vproc_cfg_unit.sv
// vset* configuration unit: waits for in-flight vector ops to drain, then commits
// the new vtype/vl atomically and returns vl to the scalar side.
module vproc_cfg_unit
  import vproc_pkg::*;
#(
  parameter int unsigned VREG_W       = 128,
  parameter int unsigned MAX_INFLIGHT = 8,
  parameter int unsigned CFG_W        = $clog2(8*VREG_W/8+1)
) (
  input  logic             clk_i,
  input  logic             sync_rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  op_mode_cfg       req_mode_i,
  input  logic [31:0]      req_avl_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_vl_o,
  input  logic             op_issue_i,
  output logic             op_issue_ready_o,
  input  logic             op_retire_i,
  output cfg_vsew          vsew_o,
  output cfg_lmul          lmul_o,
  output logic [1:0]       agnostic_o,
  output logic [CFG_W-1:0] vl_o,
  output logic             vl_0_o,
  output logic [CFG_W-1:0] vlmax_o,
  output logic             vill_o
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT+1);

  cfg_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  op_mode_cfg       req_mode_r;
  logic [31:0]      req_avl_r;
  cfg_vsew          vsew_r;
  cfg_lmul          lmul_r;
  logic [1:0]       agnostic_r;
  logic [CFG_W-1:0] vl_r, vlmax_r;
  logic             vl_0_r, vill_r, res_valid_r;
  logic [31:0]      res_vl_r;

  logic [CFG_W-1:0] calc_vlmax_s, new_vl_s;
  logic             calc_illegal_s, illegal_s;
  logic             req_fire_s, res_fire_s, commit_s, issue_acc_s, retire_acc_s;

  vproc_vlmax_calc #(
    .VREG_W (VREG_W),
    .CFG_W  (CFG_W)
  ) u_vlmax_calc (
    .vsew    (req_mode_r.vsew),
    .lmul    (req_mode_r.lmul),
    .vlmax   (calc_vlmax_s),
    .illegal (calc_illegal_s)
  );

  assign req_ready_o      = (state_r == IDLE);
  assign op_issue_ready_o = (state_r == IDLE) && (cnt_r != CNT_W'(MAX_INFLIGHT));
  assign req_fire_s       = req_valid_i && req_ready_o;
  assign res_fire_s       = res_valid_r && res_ready_i;
  assign commit_s         = (state_r == DRAIN) && (cnt_r == '0);
  assign issue_acc_s      = op_issue_i && op_issue_ready_o;
  assign retire_acc_s     = op_retire_i && (cnt_r != '0);

  // New vl selection; keep_vl is only meaningful if VLMAX is unchanged
  always_comb begin
    illegal_s = calc_illegal_s;
    new_vl_s  = '0;
    if (req_mode_r.vlmax) begin
      new_vl_s = calc_vlmax_s;
    end else if (req_mode_r.keep_vl) begin
      new_vl_s = vl_r;
      if (calc_vlmax_s != vlmax_r) begin
        illegal_s = 1'b1;
      end else begin
        illegal_s = calc_illegal_s;
      end
    end else if (req_avl_r < 32'(calc_vlmax_s)) begin
      new_vl_s = req_avl_r[CFG_W-1:0];
    end else begin
      new_vl_s = calc_vlmax_s;
    end
    if (illegal_s) begin
      new_vl_s = '0;
    end else begin
      new_vl_s = new_vl_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid_i) state_s = DRAIN;
        else             state_s = IDLE;
      end
      DRAIN: begin
        if (cnt_r == '0) state_s = RESP;
        else             state_s = DRAIN;
      end
      RESP: begin
        if (res_ready_i) state_s = IDLE;
        else             state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // In-flight op counter, saturating at both ends by construction of the accept terms
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      cnt_r <= '0;
    end else begin
      case ({issue_acc_s, retire_acc_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1'b1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1'b1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Request capture, configuration commit and response register
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      req_mode_r  <= '0;
      req_avl_r   <= 32'd0;
      vsew_r      <= VSEW_8;
      lmul_r      <= LMUL_1;
      agnostic_r  <= 2'b00;
      vl_r        <= '0;
      vl_0_r      <= 1'b1;
      vlmax_r     <= CFG_W'(VREG_W/8);
      vill_r      <= 1'b1;
      res_valid_r <= 1'b0;
      res_vl_r    <= 32'd0;
    end else begin
      if (req_fire_s) begin
        req_mode_r <= req_mode_i;
        req_avl_r  <= req_avl_i;
      end
      if (commit_s) begin
        vl_r        <= new_vl_s;
        vl_0_r      <= (new_vl_s == '0);
        res_vl_r    <= 32'(new_vl_s);
        res_valid_r <= 1'b1;
        vill_r      <= illegal_s;
        if (illegal_s) begin
          vsew_r     <= VSEW_8;
          lmul_r     <= LMUL_1;
          agnostic_r <= 2'b00;
          vlmax_r    <= CFG_W'(VREG_W/8);
        end else begin
          vsew_r     <= req_mode_r.vsew;
          lmul_r     <= req_mode_r.lmul;
          agnostic_r <= req_mode_r.agnostic;
          vlmax_r    <= calc_vlmax_s;
        end
      end else if (res_fire_s) begin
        res_valid_r <= 1'b0;
      end
    end
  end

  assign res_valid_o = res_valid_r;
  assign res_vl_o    = res_vl_r;
  assign vsew_o      = vsew_r;
  assign lmul_o      = lmul_r;
  assign agnostic_o  = agnostic_r;
  assign vl_o        = vl_r;
  assign vl_0_o      = vl_0_r;
  assign vlmax_o     = vlmax_r;
  assign vill_o      = vill_r;

endmodule

// File: tb/tb_vproc_cfg_unit.sv
// Scoreboard bench for vproc_cfg_unit: expected responses are queued at request time
// and a monitor compares them whenever the DUT presents a response.
module tb_vproc_cfg_unit;
  import vproc_pkg::*;

  localparam int VREG_W = 128;
  localparam int MAXI   = 8;
  localparam int CFG_W  = 8;

  logic             clk = 1'b0;
  logic             sync_rst_i, req_valid_i, req_ready_o, res_valid_o, res_ready_i;
  op_mode_cfg       req_mode_i;
  logic [31:0]      req_avl_i, res_vl_o;
  logic             op_issue_i, op_issue_ready_o, op_retire_i;
  cfg_vsew          vsew_o;
  cfg_lmul          lmul_o;
  logic [1:0]       agnostic_o;
  logic [CFG_W-1:0] vl_o, vlmax_o;
  logic             vl_0_o, vill_o;

  always #5 clk = ~clk;

  vproc_cfg_unit #(.VREG_W(VREG_W), .MAX_INFLIGHT(MAXI)) dut (
    .clk_i(clk), .sync_rst_i(sync_rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_mode_i(req_mode_i), .req_avl_i(req_avl_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_vl_o(res_vl_o),
    .op_issue_i(op_issue_i), .op_issue_ready_o(op_issue_ready_o), .op_retire_i(op_retire_i),
    .vsew_o(vsew_o), .lmul_o(lmul_o), .agnostic_o(agnostic_o),
    .vl_o(vl_o), .vl_0_o(vl_0_o), .vlmax_o(vlmax_o), .vill_o(vill_o)
  );

  typedef struct {
    logic [31:0] res_vl;
    logic [7:0]  vl;
    logic [7:0]  vlmax;
    logic        vill;
    cfg_vsew     vsew;
    cfg_lmul     lmul;
    logic [1:0]  agn;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic op_mode_cfg mk(cfg_vsew s, cfg_lmul l, logic [1:0] a, logic vm, logic kv);
    return '{vsew: s, lmul: l, agnostic: a, vlmax: vm, keep_vl: kv};
  endfunction

  function automatic exp_t ex(logic [31:0] rv, logic [7:0] vl, logic [7:0] vm, logic vill,
                              cfg_vsew s, cfg_lmul l, logic [1:0] a);
    exp_t r;
    r.res_vl = rv; r.vl = vl; r.vlmax = vm; r.vill = vill; r.vsew = s; r.lmul = l; r.agn = a;
    return r;
  endfunction

  // Monitor: compare every presented response (and the committed config) against the queue
  always @(negedge clk) begin : monitor
    exp_t e;
    if (res_valid_o && res_ready_i) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got res_vl %0d with empty queue", res_vl_o);
      end else begin
        e = q.pop_front();
        chk("res_vl", res_vl_o, e.res_vl);
        chk("vl", vl_o, e.vl);
        chk("vl_0", vl_0_o, e.vl == 8'd0);
        chk("vlmax", vlmax_o, e.vlmax);
        chk("vill", vill_o, e.vill);
        chk("vsew", vsew_o, e.vsew);
        chk("lmul", lmul_o, e.lmul);
        chk("agnostic", agnostic_o, e.agn);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake(input op_mode_cfg m, input logic [31:0] avl, input exp_t e, input bit push);
    req_mode_i  = m;
    req_avl_i   = avl;
    req_valid_i = 1'b1;
    @(negedge clk);
    chk("req_ready", req_ready_o, 1);
    if (push) q.push_back(e);
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_resp(input int exp_lat);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid_o && lat < 50);
    if (!res_valid_o) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: no res_valid_o within %0d cycles", lat);
    end else if (exp_lat > 0) begin
      chk("latency", lat, exp_lat);
    end
    if (res_ready_i) tick();
  endtask

  task automatic req(input op_mode_cfg m, input logic [31:0] avl, input exp_t e);
    handshake(m, avl, e, 1'b1);
    wait_resp(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    sync_rst_i = 1'b1; req_valid_i = 1'b0; req_mode_i = '0; req_avl_i = 32'd0;
    res_ready_i = 1'b1; op_issue_i = 1'b0; op_retire_i = 1'b0;
    repeat (2) tick();
    sync_rst_i = 1'b0;
    @(negedge clk);
    chk("rst_vill", vill_o, 1);
    chk("rst_vl", vl_o, 0);
    chk("rst_vl_0", vl_0_o, 1);
    chk("rst_vlmax", vlmax_o, 16);
    chk("rst_vsew", vsew_o, VSEW_8);
    chk("rst_lmul", lmul_o, LMUL_1);
    chk("rst_agnostic", agnostic_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_res_vl", res_vl_o, 0);
    chk("rst_issue_ready", op_issue_ready_o, 1);
    tick();

    // Legal configurations
    req(mk(VSEW_32, LMUL_1, 2'd0, 1'b0, 1'b0), 32'd10, ex(4, 4, 4, 0, VSEW_32, LMUL_1, 2'd0));
    req(mk(VSEW_8, LMUL_8, 2'd0, 1'b1, 1'b0), 32'd0, ex(128, 128, 128, 0, VSEW_8, LMUL_8, 2'd0));
    req(mk(VSEW_16, LMUL_2, 2'd3, 1'b0, 1'b0), 32'd5, ex(5, 5, 16, 0, VSEW_16, LMUL_2, 2'd3));
    req(mk(VSEW_16, LMUL_F2, 2'd1, 1'b0, 1'b0), 32'd3, ex(3, 3, 4, 0, VSEW_16, LMUL_F2, 2'd1));
    req(mk(VSEW_32, LMUL_1, 2'd0, 1'b0, 1'b1), 32'd99, ex(3, 3, 4, 0, VSEW_32, LMUL_1, 2'd0));

    // Drain: three ops in flight, stray issue attempts must be refused
    op_issue_i = 1'b1;
    repeat (3) tick();
    op_issue_i = 1'b0;
    handshake(mk(VSEW_8, LMUL_1, 2'd0, 1'b0, 1'b0), 32'd0, ex(0, 0, 16, 0, VSEW_8, LMUL_1, 2'd0), 1'b1);
    op_issue_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("drain_hold_valid", res_valid_o, 0);
      chk("drain_issue_ready", op_issue_ready_o, 0);
      chk("drain_old_vl", vl_o, 3);
      tick();
    end
    op_retire_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("drain_retire_valid", res_valid_o, 0);
      chk("drain_retire_issue_ready", op_issue_ready_o, 0);
      tick();
    end
    op_retire_i = 1'b0;
    op_issue_i  = 1'b0;
    wait_resp(2);

    // Illegal configurations
    req(mk(VSEW_32, LMUL_F8, 2'd2, 1'b0, 1'b0), 32'd10, ex(0, 0, 16, 1, VSEW_8, LMUL_1, 2'd0));
    req(mk(VSEW_32, LMUL_1, 2'd0, 1'b0, 1'b1), 32'd10, ex(0, 0, 16, 1, VSEW_8, LMUL_1, 2'd0));
    req(mk(VSEW_32, LMUL_F2, 2'd0, 1'b0, 1'b0), 32'd1, ex(0, 0, 16, 1, VSEW_8, LMUL_1, 2'd0));
    req(mk(VSEW_INVALID, LMUL_1, 2'd0, 1'b0, 1'b0), 32'd1, ex(0, 0, 16, 1, VSEW_8, LMUL_1, 2'd0));
    req(mk(VSEW_16, LMUL_1, 2'd0, 1'b0, 1'b0), 32'd20, ex(8, 8, 8, 0, VSEW_16, LMUL_1, 2'd0));

    // Counter saturation at MAX_INFLIGHT and at zero
    op_issue_i = 1'b1;
    for (int i = 0; i < MAXI; i++) begin
      @(negedge clk);
      chk("fill_issue_ready", op_issue_ready_o, 1);
      tick();
    end
    @(negedge clk);
    chk("full_issue_ready", op_issue_ready_o, 0);
    op_retire_i = 1'b1;
    tick();
    op_issue_i  = 1'b0;
    op_retire_i = 1'b0;
    @(negedge clk);
    chk("full_issue_retire_ready", op_issue_ready_o, 1);
    tick();
    op_issue_i = 1'b1;
    tick();
    op_issue_i = 1'b0;
    @(negedge clk);
    chk("refill_issue_ready", op_issue_ready_o, 0);
    tick();
    op_retire_i = 1'b1;
    repeat (MAXI + 1) tick();
    op_retire_i = 1'b0;
    op_issue_i  = 1'b1;
    for (int i = 0; i < MAXI; i++) begin
      @(negedge clk);
      chk("post_underflow_ready", op_issue_ready_o, 1);
      tick();
    end
    op_issue_i = 1'b0;
    @(negedge clk);
    chk("post_underflow_full", op_issue_ready_o, 0);
    tick();
    op_retire_i = 1'b1;
    repeat (MAXI) tick();
    op_retire_i = 1'b0;
    req(mk(VSEW_8, LMUL_F2, 2'd0, 1'b0, 1'b0), 32'd5, ex(5, 5, 8, 0, VSEW_8, LMUL_F2, 2'd0));

    // Response hold, then reset in RESP abandons it
    res_ready_i = 1'b0;
    handshake(mk(VSEW_16, LMUL_1, 2'd0, 1'b0, 1'b0), 32'd7, ex(7, 7, 8, 0, VSEW_16, LMUL_1, 2'd0), 1'b0);
    wait_resp(2);
    repeat (3) begin
      tick();
      @(negedge clk);
      chk("hold_valid", res_valid_o, 1);
      chk("hold_res_vl", res_vl_o, 7);
    end
    tick();
    sync_rst_i = 1'b1;
    tick();
    sync_rst_i  = 1'b0;
    res_ready_i = 1'b1;
    req_mode_i  = mk(VSEW_32, LMUL_2, 2'd0, 1'b0, 1'b0);
    req_avl_i   = 32'd6;
    req_valid_i = 1'b1;
    @(negedge clk);
    chk("rstresp_valid", res_valid_o, 0);
    chk("rstresp_vill", vill_o, 1);
    chk("rstresp_req_ready", req_ready_o, 1);
    q.push_back(ex(6, 6, 8, 0, VSEW_32, LMUL_2, 2'd0));
    tick();
    req_valid_i = 1'b0;
    wait_resp(2);

    repeat (3) tick();
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vproc_cfg_unit.md
VPROC_CFG_UNIT -- requirements
Module: vproc_cfg_unit

Interface
REQ-001 SHALL have parameter VREG_W, default 128, giving the vector register width in bits (power of two, at least 64).
REQ-002 SHALL have parameter MAX_INFLIGHT, default 8, giving the maximum number of issued, unretired vector ops tracked.
REQ-003 SHALL have parameter CFG_W, default $clog2(8*VREG_W/8+1), giving the width of the vl and VLMAX fields.
REQ-004 SHALL have port clk_i, input, 1 bit: the only clock, rising edge.
REQ-005 SHALL have port sync_rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have ports req_valid_i (input, 1) and req_ready_o (output, 1): vset* request handshake.
REQ-007 SHALL have port req_mode_i, input, op_mode_cfg: requested vsew, lmul, agnostic, vlmax and keep_vl.
REQ-008 SHALL have port req_avl_i, input, 32 bits: the application vector length.
REQ-009 SHALL have ports res_valid_o (output, 1), res_ready_i (input, 1) and res_vl_o (output, 32): the new vl returned to the scalar rd.
REQ-010 SHALL have ports op_issue_i (input, 1), op_issue_ready_o (output, 1) and op_retire_i (input, 1): in-flight op tracking.
REQ-011 SHALL have outputs vsew_o (cfg_vsew), lmul_o (cfg_lmul), agnostic_o (2), vl_o (CFG_W), vl_0_o (1), vlmax_o (CFG_W) and vill_o (1): the committed configuration.

Function
REQ-012 SHALL compute VLMAX as (VREG_W/8) >> vsew, shifted left by lmul for LMUL_1..LMUL_8 and right by 1/2/3 for LMUL_F2/F4/F8.
REQ-013 SHALL treat a request as illegal when vsew is VSEW_INVALID, lmul is LMUL_INVALID, SEW > LMUL*32, or the computed VLMAX is 0.
REQ-014 SHALL set new vl as follows: req vlmax set -> VLMAX; keep_vl set -> old vl; otherwise min(AVL, VLMAX).
REQ-015 SHALL treat keep_vl as illegal when the new VLMAX differs from the current vlmax_o.
REQ-016 SHALL, for an illegal request, commit vill=1, vl=0, vsew=VSEW_8, lmul=LMUL_1 and agnostic=0, and return res_vl_o=0.
REQ-017 SHALL implement an FSM with states IDLE, DRAIN and RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-018 SHALL move from IDLE to DRAIN on a req handshake, capturing req_mode_i and req_avl_i.
REQ-019 SHALL stay in DRAIN while the in-flight count is non-zero.
REQ-020 SHALL, in DRAIN with count==0, update all configuration outputs at that clock edge and move to RESP.
REQ-021 SHALL hold res_valid_o=1 in RESP, with res_vl_o stable until res_ready_i, then return to IDLE.
REQ-022 SHALL keep op_issue_ready_o=0 outside IDLE and when count==MAX_INFLIGHT; issue attempts without ready SHALL be ignored.
REQ-023 SHALL count one accepted issue as +1 and one retire as -1; both in the same cycle SHALL leave the count unchanged.
REQ-024 SHALL ignore a retire at count==0, leaving the count at 0 (no wrap), and SHALL never let the count exceed MAX_INFLIGHT.
REQ-025 SHALL give minimum latency, with count==0, of handshake at T, configuration visible at T+2 and res_valid_o=1 at T+2.
REQ-026 SHALL drive vl_0_o=1 exactly when the committed vl==0.

Reset
REQ-027 SHALL, when sync_rst_i is asserted, force state IDLE, count 0, vsew VSEW_8, lmul LMUL_1, agnostic 0, vl 0, vlmax VREG_W/8, vill 1, res_valid_o 0 and res_vl_o 0.
REQ-028 SHALL, on reset in DRAIN or RESP, abandon the pending request with no response, and accept a new request at the first cycle after reset deasserts.

Structure
REQ-029 SHALL take cfg_vsew, cfg_lmul and op_mode_cfg from vproc_pkg, and add the FSM state enum cfg_state_e to vproc_pkg.
REQ-030 SHALL place the VLMAX/legality logic in a combinational sub-module vproc_vlmax_calc(vsew, lmul -> vlmax, illegal), reused by the decoder.

Verification
REQ-031 SHALL test SEW32/LMUL_1 with AVL=10, count 0: res_vl_o=4 at T+2, vlmax_o=4, vill_o=0.
REQ-032 SHALL test SEW8/LMUL_8 with vlmax flag set: vl_o=128, vlmax_o=128.
REQ-033 SHALL test count=3 with a request at T: DRAIN held until 3 retires, commit on the edge after count reaches 0, op_issue_ready_o=0 throughout.
REQ-034 SHALL test SEW32/LMUL_F8: vill_o=1, vl_o=0, res_vl_o=0; then keep_vl with a changed VLMAX: vill_o=1.
REQ-035 SHALL test count at MAX_INFLIGHT with simultaneous issue+retire: issue is refused and the count drops to MAX_INFLIGHT-1; retire at count 0 leaves the count at 0.
REQ-036 SHALL test sync_rst_i pulsed in RESP: res_valid_o=0 and vill_o=1 the next cycle, and a new request is accepted the cycle after.
